// File: rtl/phy_tx_serdes_n_if.sv
// Lane-side bundle of the parallel-to-serial PHY transmitter.
// The master drives lane words and idle requests, and the slave returns the serial line and framing status.
interface phy_tx_serdes_n_if #(
    parameter int N_LANES = 4,
    parameter int W       = 8
);
    logic                         idle_req;
    logic [N_LANES-1:0]           valid_in;
    logic [N_LANES*W-1:0]         data_in;
    logic                         frame_strobe;
    logic [$clog2(N_LANES)-1:0]   slot_idx;
    logic                         tx_active;
    logic                         serial_out;

    modport master (
        output idle_req, valid_in, data_in,
        input  frame_strobe, slot_idx, tx_active, serial_out
    );

    modport slave (
        input  idle_req, valid_in, data_in,
        output frame_strobe, slot_idx, tx_active, serial_out
    );
endinterface

// File: rtl/phy_tx_serdes_n.sv
// Round-robin serialiser of N_LANES W-bit lanes onto one bit line, with a COM sync preamble after reset.
// Lane i of a sampled frame appears i*W+1 cycles after the strobe edge. There is no backpressure: the inputs are sampled only at frame_strobe.
module phy_tx_serdes_n #(
    parameter int           N_LANES     = 4,
    parameter int           W           = 8,
    parameter logic [W-1:0] COM_SYM     = 'hBC,
    parameter logic [W-1:0] IDLE_SYM    = 'h7C,
    parameter int           SYNC_FRAMES = 2,
    parameter bit           MSB_FIRST   = 1'b1
) (
    input  logic               clk_fast,
    input  logic               rst,
    phy_tx_serdes_n_if.slave   tx
);
    localparam int SW = $clog2(N_LANES);
    localparam int BW = $clog2(W);
    localparam int CW = $clog2(SYNC_FRAMES + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(N_LANES - 1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_FRAMES);

    typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BW-1:0]      bit_cnt;
    logic [SW-1:0]      slot;
    logic [SW-1:0]      slot_nxt;
    logic [CW-1:0]      sync_cnt;
    logic [W-1:0]       shreg;
    logic [W-1:0]       cap_dat [N_LANES];
    logic [N_LANES-1:0] cap_vld;

    logic               word_end;
    logic               strobe;
    logic               run_sel;
    logic               lane_vld;
    logic [W-1:0]       lane_dat;
    logic [W-1:0]       word_nxt;

    assign word_end = (bit_cnt == BIT_LAST);
    assign strobe   = rst & word_end & (slot == SLOT_LAST);
    assign slot_nxt = slot + 1'b1;

    always_ff @(posedge clk_fast) begin
        if (!rst) state <= ST_SYNC;
        else      state <= state_nxt;
    end

    // run_sel lets the RUN-entry edge already load lane data for slot 0.
    always_comb begin
        state_nxt = state;
        run_sel   = (state == ST_RUN);
        if (state == ST_SYNC && strobe && sync_cnt == SYNC_LAST) begin
            state_nxt = ST_RUN;
            run_sel   = 1'b1;
        end
    end

    // Slot 0 bypasses the capture registers so frames run back to back.
    always_comb begin
        lane_dat = cap_dat[slot_nxt];
        lane_vld = cap_vld[slot_nxt];
        if (strobe) begin
            lane_dat = tx.data_in[W-1:0];
            lane_vld = tx.valid_in[0];
        end
        if (!run_sel)                     word_nxt = COM_SYM;
        else if (tx.idle_req || !lane_vld) word_nxt = IDLE_SYM;
        else                              word_nxt = lane_dat;
    end

    always_ff @(posedge clk_fast) begin
        if (!rst) begin
            bit_cnt  <= BIT_LAST;
            slot     <= SLOT_LAST;
            sync_cnt <= '0;
            shreg    <= '0;
            cap_vld  <= '0;
            for (int i = 0; i < N_LANES; i++) cap_dat[i] <= '0;
        end else begin
            bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
            if (word_end) begin
                slot  <= slot_nxt;
                shreg <= word_nxt;
            end else if (MSB_FIRST) begin
                shreg <= {shreg[W-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[W-1:1]};
            end
            if (strobe) begin
                if (state == ST_SYNC && sync_cnt != SYNC_LAST) sync_cnt <= sync_cnt + 1'b1;
                for (int i = 1; i < N_LANES; i++) begin
                    cap_dat[i] <= tx.data_in[i*W +: W];
                    cap_vld[i] <= tx.valid_in[i];
                end
            end
        end
    end

    assign tx.serial_out   = MSB_FIRST ? shreg[W-1] : shreg[0];
    assign tx.frame_strobe = strobe;
    assign tx.slot_idx     = slot;
    assign tx.tx_active    = (state == ST_RUN);
endmodule

// File: tb/tb_phy_tx_serdes_n.sv
// Bench for phy_tx_serdes_n: one default instance and one 8-lane, 10-bit, LSB-first instance.
// A cycle-indexed frame model checks every output each cycle, and directed literal words pin that model.
module tb_phy_tx_serdes_n;
    localparam int N0 = 4, W0 = 8, N1 = 8, W1 = 10;
    localparam logic [79:0] D1 = {10'h2AA, 10'h155, 10'h300, 10'h0FF,
                                  10'h13C, 10'h2C3, 10'h05A, 10'h3A5};

    logic clk_fast = 1'b0;
    logic rst0, rst1;
    always #5 clk_fast = ~clk_fast;

    phy_tx_serdes_n_if #(.N_LANES(N0), .W(W0)) if0();
    phy_tx_serdes_n_if #(.N_LANES(N1), .W(W1)) if1();

    phy_tx_serdes_n u0 (.clk_fast(clk_fast), .rst(rst0), .tx(if0));
    phy_tx_serdes_n #(.N_LANES(N1), .W(W1), .COM_SYM(10'h283), .IDLE_SYM(10'h17C),
                      .SYNC_FRAMES(1), .MSB_FIRST(1'b0))
        u1 (.clk_fast(clk_fast), .rst(rst1), .tx(if1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: per instance, m counts cycles since reset release; word k loads at m=k*W.
    int          NL[2]   = '{N0, N1};
    int          WL[2]   = '{W0, W1};
    int          SF[2]   = '{2, 1};
    bit          MF[2]   = '{1'b1, 1'b0};
    logic [15:0] COMW[2] = '{16'h0BC, 16'h283};
    logic [15:0] IDLW[2] = '{16'h07C, 16'h17C};

    int          m[2]     = '{-1, -1};
    bit          armed[2] = '{1'b0, 1'b0};
    logic [15:0] word[2];
    int          pos[2];
    logic        e_ser[2], e_tx[2], e_strb[2];
    int          e_slot[2];
    logic [15:0] cap_d[2][8];
    logic [7:0]  cap_v[2];

    logic        mr[2], midl[2], mso[2], mfs[2], mtx[2];
    logic [7:0]  mv[2];
    logic [15:0] md[2][8];
    int          msl[2];
    int          wi, fi, si;

    always @(negedge clk_fast) begin
        mr[0] = rst0; midl[0] = if0.idle_req; mv[0] = {4'b0, if0.valid_in};
        mso[0] = if0.serial_out; mfs[0] = if0.frame_strobe; mtx[0] = if0.tx_active;
        msl[0] = int'(if0.slot_idx);
        mr[1] = rst1; midl[1] = if1.idle_req; mv[1] = if1.valid_in;
        mso[1] = if1.serial_out; mfs[1] = if1.frame_strobe; mtx[1] = if1.tx_active;
        msl[1] = int'(if1.slot_idx);
        for (int j = 0; j < 8; j++) begin
            md[0][j] = (j < N0) ? 16'(if0.data_in[j*W0 +: W0]) : 16'h0;
            md[1][j] = 16'(if1.data_in[j*W1 +: W1]);
        end
        for (int k = 0; k < 2; k++) begin
            if (armed[k]) begin
                check($sformatf("u%0d serial_out", k), mso[k], e_ser[k]);
                check($sformatf("u%0d tx_active", k), mtx[k], e_tx[k]);
                check($sformatf("u%0d slot_idx", k), msl[k], e_slot[k]);
                check($sformatf("u%0d frame_strobe", k), mfs[k], e_strb[k] & mr[k]);
            end
            if (!mr[k]) begin
                armed[k] = 1'b1; m[k] = 0;
                e_ser[k] = 1'b0; e_tx[k] = 1'b0; e_slot[k] = NL[k] - 1; e_strb[k] = 1'b1;
            end else if (m[k] >= 0) begin
                if (m[k] % WL[k] == 0) begin
                    wi = m[k] / WL[k]; fi = wi / NL[k]; si = wi % NL[k];
                    if (si == 0) begin
                        cap_v[k] = mv[k];
                        for (int j = 0; j < 8; j++) cap_d[k][j] = md[k][j];
                    end
                    if (fi < SF[k])                      word[k] = COMW[k];
                    else if (midl[k] || !cap_v[k][si])  word[k] = IDLW[k];
                    else                                word[k] = cap_d[k][si];
                    pos[k] = 0; e_slot[k] = si; e_tx[k] = (fi >= SF[k]);
                end else begin
                    pos[k]++;
                end
                e_ser[k] = MF[k] ? word[k][WL[k]-1-pos[k]] : word[k][pos[k]];
                m[k]++;
                e_strb[k] = (m[k] % (NL[k] * WL[k]) == 0);
            end
        end
    end

    task automatic wait_strobe(input int k);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_fast);
            if (((k == 0) ? if0.frame_strobe : if1.frame_strobe) === 1'b1) seen = 1'b1;
        end
        check($sformatf("u%0d strobe seen", k), seen, 1'b1);
        @(posedge clk_fast); #2;
    endtask

    task automatic grab(input int k, output logic [15:0] w, output int sl);
        logic b;
        w = '0; sl = -1;
        for (int i = 0; i < WL[k]; i++) begin
            @(negedge clk_fast);
            if (i == 0) sl = (k == 0) ? int'(if0.slot_idx) : int'(if1.slot_idx);
            b = (k == 0) ? if0.serial_out : if1.serial_out;
            if (MF[k]) w[WL[k]-1-i] = b;
            else       w[i] = b;
        end
    endtask

    // e lists the 4 words of a u0 frame, word 0 in the top byte.
    task automatic words0(input logic [31:0] e, input int first, input int cnt, input string tag);
        logic [15:0] w;
        int          sl;
        for (int s = first; s < first + cnt; s++) begin
            grab(0, w, sl);
            check($sformatf("%s word%0d", tag, s), w, 32'(e[8*(3-s) +: 8]));
            check($sformatf("%s slot%0d", tag, s), sl, s);
        end
    endtask

    task automatic frame1(input logic [7:0] vmask, input bit com, input string tag);
        logic [15:0] w;
        logic [9:0]  ev;
        int          sl;
        for (int s = 0; s < N1; s++) begin
            grab(1, w, sl);
            ev = com ? 10'h283 : (vmask[s] ? D1[s*10 +: 10] : 10'h17C);
            check($sformatf("%s word%0d", tag, s), w, 32'(ev));
            check($sformatf("%s slot%0d", tag, s), sl, s);
        end
    endtask

    initial begin
        int cnt;
        rst0 = 1'b0; rst1 = 1'b0;
        if0.idle_req = 1'b0; if0.valid_in = '0; if0.data_in = '0;
        if1.idle_req = 1'b0; if1.valid_in = '0; if1.data_in = '0;
        repeat (5) @(posedge clk_fast);
        @(negedge clk_fast);
        check("reset serial_out", if0.serial_out, 1'b0);
        check("reset tx_active", if0.tx_active, 1'b0);
        check("reset slot_idx", if0.slot_idx, 2'd3);
        check("reset frame_strobe", if0.frame_strobe, 1'b0);
        @(posedge clk_fast); #2 rst0 = 1'b1;

        wait_strobe(0);
        words0(32'hBCBCBCBC, 0, 4, "sync0");
        check("tx before run", if0.tx_active, 1'b0);
        @(posedge clk_fast); #2;
        if0.valid_in = 4'hF; if0.data_in = 32'h44332211;
        words0(32'hBCBCBCBC, 0, 4, "sync1");
        check("tx last sync bit", if0.tx_active, 1'b0);
        @(posedge clk_fast); #2;
        check("tx rise", if0.tx_active, 1'b1);
        if0.valid_in = 4'b0101;
        words0(32'h11223344, 0, 4, "all valid");
        words0(32'h117C337C, 0, 2, "partial");
        @(posedge clk_fast); #2 if0.data_in = 32'hDEADBEEF;
        words0(32'h117C337C, 2, 2, "partial");
        @(posedge clk_fast); #2 if0.valid_in = 4'hF; if0.data_in = 32'h44332211;
        words0(32'hEF7CAD7C, 0, 4, "late data");
        @(posedge clk_fast); #2 if0.data_in = 32'h88776655;
        words0(32'h11223344, 0, 1, "idle mid");
        @(posedge clk_fast); #2 if0.idle_req = 1'b1;
        words0(32'h11227C7C, 1, 3, "idle mid");
        @(posedge clk_fast); #2 if0.idle_req = 1'b0;
        words0(32'h7C667788, 0, 4, "idle strobe");
        words0(32'h55667788, 0, 1, "pre reset");
        repeat (3) @(negedge clk_fast);
        @(posedge clk_fast); #2 rst0 = 1'b0;
        @(negedge clk_fast);
        @(negedge clk_fast);
        check("midword rst serial_out", if0.serial_out, 1'b0);
        check("midword rst tx_active", if0.tx_active, 1'b0);
        @(posedge clk_fast); #2 rst0 = 1'b1;
        wait_strobe(0);
        words0(32'hBCBCBCBC, 0, 4, "resync0");
        words0(32'hBCBCBCBC, 0, 4, "resync1");
        words0(32'h55667788, 0, 4, "after resync");

        if1.valid_in = 8'hFF; if1.data_in = D1;
        @(posedge clk_fast); #2 rst1 = 1'b1;
        wait_strobe(1);
        frame1(8'hFF, 1'b1, "w10 sync");
        check("w10 tx before run", if1.tx_active, 1'b0);
        @(posedge clk_fast); #2;
        check("w10 tx rise", if1.tx_active, 1'b1);
        if1.valid_in = 8'hA5;
        frame1(8'hFF, 1'b0, "w10 all");
        frame1(8'hA5, 1'b0, "w10 masked");
        @(posedge clk_fast); #2;
        cnt = 0;
        while (cnt < 200 && if1.frame_strobe !== 1'b1) begin
            @(negedge clk_fast);
            cnt++;
        end
        check("w10 frame period", cnt, 80);

        repeat (3) @(posedge clk_fast);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
